// File: rtl/sb3320_path_sequencer.sv
// Route sequencer: replays a preloaded list of turn codes node by node toward the turn stage.
// Optional TURN watchdog enabled by defining SB3320_TURN_TIMEOUT_EN.
module sb3320_path_sequencer #(
    parameter int DEPTH    = 16,
    parameter int IDX_W    = 4,
    parameter int DEBOUNCE = 8,
    parameter int TIMEOUT  = 50_000_000
) (
    input  logic             clk_50,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [2:0]       wr_data,
    input  logic             run,
    input  logic             abort,
    input  logic             sensor_l,
    input  logic             sensor_m,
    input  logic             sensor_r,
    input  logic             turn_done,
    output logic [2:0]       turn,
    output logic             start,
    output logic             busy,
    output logic             route_done,
    output logic             fault,
    output logic [IDX_W-1:0] node_idx
);

    typedef enum logic [2:0] {
        IDLE, FOLLOW, TURN, CLEAR, FINISH, FAULT
    } state_t;

    localparam int DEB_W = $clog2(DEBOUNCE + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE - 1);
    localparam logic [IDX_W:0]   DEPTH_C  = (IDX_W + 1)'(DEPTH);
    localparam logic [2:0] CODE_STOP = 3'b000;
    localparam logic [2:0] CODE_FWD  = 3'b001;
    localparam logic [2:0] CODE_MAX  = 3'b100;

    state_t            state, state_n;
    logic [2:0]        route_mem [DEPTH];
    logic [IDX_W:0]    count, count_eff, idx;
    logic [DEB_W-1:0]  deb_cnt;
    logic [2:0]        cur_code;
    logic              all_high, wr_ok;

`ifdef SB3320_TURN_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    logic [TMO_W-1:0]  tmo_cnt;
`endif

    assign all_high  = sensor_l & sensor_m & sensor_r;
    assign wr_ok     = (state == IDLE) && wr_en && !abort && (count != DEPTH_C);
    // A write in the same cycle as run is visible to the run decision.
    assign count_eff = count + {{IDX_W{1'b0}}, wr_ok};
    assign cur_code  = route_mem[idx[IDX_W-1:0]];
    assign node_idx  = idx[IDX_W-1:0];

    always_ff @(posedge clk_50) begin
        if (wr_ok) begin
            route_mem[count[IDX_W-1:0]] <= wr_data;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (run) state_n = (count_eff == '0) ? FINISH : FOLLOW;
            end
            FOLLOW: begin
                if (all_high && deb_cnt == DEB_LAST) begin
                    if (cur_code == CODE_STOP)     state_n = FINISH;
                    else if (cur_code > CODE_MAX)  state_n = FAULT;
                    else                           state_n = TURN;
                end
            end
            TURN: begin
                if (turn_done) state_n = CLEAR;
`ifdef SB3320_TURN_TIMEOUT_EN
                else if (tmo_cnt == TMO_LAST) state_n = FAULT;
`endif
            end
            CLEAR: begin
                if (!all_high) state_n = (idx == count) ? FINISH : FOLLOW;
            end
            FINISH: begin
                if (run) state_n = (count == '0) ? FINISH : FOLLOW;
            end
            FAULT:   state_n = FAULT;
            default: state_n = IDLE;
        endcase
        if (abort) state_n = IDLE;
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            idx        <= '0;
            deb_cnt    <= '0;
            turn       <= CODE_STOP;
            start      <= 1'b0;
            busy       <= 1'b0;
            route_done <= 1'b0;
            fault      <= 1'b0;
        end else begin
            state <= state_n;
            if (wr_ok) count <= count + 1'b1;

            if (abort || ((state == IDLE || state == FINISH) && run)) idx <= '0;
            else if (state == TURN && turn_done) idx <= idx + 1'b1;

            if (state_n == FOLLOW && state != FOLLOW) deb_cnt <= '0;
            else if (state == FOLLOW) deb_cnt <= all_high ? deb_cnt + 1'b1 : '0;

            case (state_n)
                TURN:          turn <= cur_code;
                FOLLOW, CLEAR: turn <= CODE_FWD;
                default:       turn <= CODE_STOP;
            endcase
            start      <= (state_n == TURN);
            busy       <= (state_n == FOLLOW) || (state_n == TURN) || (state_n == CLEAR);
            route_done <= (state_n == FINISH);
            fault      <= (state_n == FAULT);
        end
    end

`ifdef SB3320_TURN_TIMEOUT_EN
    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst)                 tmo_cnt <= '0;
        else if (state != TURN)  tmo_cnt <= '0;
        else                     tmo_cnt <= tmo_cnt + 1'b1;
    end
`endif

endmodule
